// File: rtl/arb_pkg.sv
// Shared constants and state type for the four-requester bus arbiter.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int SEL_W   = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin picker: the first active request at or after the
// pointer, wrapping from the highest requester back to requester 0.
module arb_rr_pick
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [SEL_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_pick,
    output logic [SEL_W-1:0]   o_idx,
    output logic               o_any
);

    logic [SEL_W-1:0] w_cand;
    logic             w_found;

    // The candidate index wraps naturally because it is only SEL_W bits wide.
    always_comb begin
        o_pick  = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = i_ptr + SEL_W'(k);
            if (!w_found && i_req[w_cand]) begin
                w_found        = 1'b1;
                o_idx          = w_cand;
                o_pick[w_cand] = 1'b1;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/bus_arbiter4.sv
// Four-way round-robin arbiter driving a shared 4:1 data select.
// Define ARB_TIMEOUT_EN to abort grants that wait TIMEOUT_CYCLES for RES_READY.
module bus_arbiter4
    import arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] REQ,
    input  logic [DATA_W-1:0]  DATA_A,
    input  logic [DATA_W-1:0]  DATA_B,
    input  logic [DATA_W-1:0]  DATA_C,
    input  logic [DATA_W-1:0]  DATA_D,
    input  logic               RES_READY,
    output logic [NUM_REQ-1:0] GNT,
    output logic [SEL_W-1:0]   MUX_OP,
    output logic               BUS_VALID,
    output logic [DATA_W-1:0]  BUS_DATA,
    output logic [NUM_REQ-1:0] ACK,
    output logic               TIMEOUT_ERR
);

    if (TIMEOUT_CYCLES < 1) begin : g_badTimeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_t         r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [SEL_W-1:0]   r_mux;
    logic [SEL_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] w_pick;
    logic [SEL_W-1:0]   w_idx;
    logic               w_any;
    logic               w_busy;
    logic [DATA_W-1:0]  w_busData;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_waitCnt;
    logic             r_timeoutErr;
`endif

    arb_rr_pick u_pick (
        .i_req  (REQ),
        .i_ptr  (r_ptr),
        .o_pick (w_pick),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    // Leaving BUSY always goes through IDLE, so grants are never back-to-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_gnt        <= '0;
            r_mux        <= '0;
            r_ptr        <= '0;
`ifdef ARB_TIMEOUT_EN
            r_waitCnt    <= '0;
            r_timeoutErr <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_pick;
                        r_mux   <= w_idx;
                        r_state <= BUSY;
                    end else begin
                        r_gnt <= '0;
                    end
                end
                BUSY: begin
                    if (RES_READY) begin
                        r_state   <= IDLE;
                        r_gnt     <= '0;
                        r_ptr     <= r_mux + 1'b1;
`ifdef ARB_TIMEOUT_EN
                        r_waitCnt <= '0;
                    end else if (r_waitCnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_state      <= IDLE;
                        r_gnt        <= '0;
                        r_ptr        <= r_mux + 1'b1;
                        r_waitCnt    <= '0;
                        r_timeoutErr <= 1'b1;
                    end else begin
                        r_waitCnt <= r_waitCnt + CNT_W'(1);
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_busy = (r_state == BUSY);

    always_comb begin
        w_busData = '0;
        if (w_busy) begin
            case (r_mux)
                2'd0: w_busData = DATA_A;
                2'd1: w_busData = DATA_B;
                2'd2: w_busData = DATA_C;
                2'd3: w_busData = DATA_D;
            endcase
        end
    end

    assign GNT       = r_gnt;
    assign MUX_OP    = r_mux;
    assign BUS_VALID = w_busy;
    assign BUS_DATA  = w_busData;
    assign ACK       = (w_busy && RES_READY) ? r_gnt : '0;

`ifdef ARB_TIMEOUT_EN
    assign TIMEOUT_ERR = r_timeoutErr;
`else
    assign TIMEOUT_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter4.sv
// Self-checking bench for bus_arbiter4: vector table, corner sequences and a
// randomized run against a behavioural model of the round-robin rules.
module tb_bus_arbiter4;

    localparam int TO = 16;
    localparam logic [31:0] DA = 32'h1111_000A;
    localparam logic [31:0] DB = 32'h2222_000B;
    localparam logic [31:0] DC = 32'h3333_000C;
    localparam logic [31:0] DD = 32'h4444_000D;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  REQ;
    logic [31:0] DATA_A, DATA_B, DATA_C, DATA_D;
    logic        RES_READY;
    logic [3:0]  GNT;
    logic [1:0]  MUX_OP;
    logic        BUS_VALID;
    logic [31:0] BUS_DATA;
    logic [3:0]  ACK;
    logic        TIMEOUT_ERR;

    int testsRun = 0;
    int testsFailed = 0;

    int   mOwner, mPtr, mMux, mWait;
    logic mErr;

    typedef struct {
        logic [3:0]  req;
        logic        ready;
        logic [3:0]  expGnt;
        logic [1:0]  expMux;
        logic        expValid;
        logic [31:0] expData;
        logic [3:0]  expAck;
    } vec_t;

    vec_t tbl[10];

    bus_arbiter4 #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .REQ         (REQ),
        .DATA_A      (DATA_A),
        .DATA_B      (DATA_B),
        .DATA_C      (DATA_C),
        .DATA_D      (DATA_D),
        .RES_READY   (RES_READY),
        .GNT         (GNT),
        .MUX_OP      (MUX_OP),
        .BUS_VALID   (BUS_VALID),
        .BUS_DATA    (BUS_DATA),
        .ACK         (ACK),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    always #5 clk = ~clk;

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] eG, input logic [1:0] eM,
                               input logic eV, input logic [31:0] eD, input logic [3:0] eA,
                               input logic eE);
        checkField({tag, ".GNT"},         32'(GNT),         32'(eG));
        checkField({tag, ".MUX_OP"},      32'(MUX_OP),      32'(eM));
        checkField({tag, ".BUS_VALID"},   32'(BUS_VALID),   32'(eV));
        checkField({tag, ".BUS_DATA"},    BUS_DATA,         eD);
        checkField({tag, ".ACK"},         32'(ACK),         32'(eA));
        checkField({tag, ".TIMEOUT_ERR"}, 32'(TIMEOUT_ERR), 32'(eE));
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic ready);
        REQ       = req;
        RES_READY = ready;
    endtask

    // Inputs change just after a rising edge; outputs are checked on the falling edge.
    task automatic runCycle(input logic [3:0] req, input logic ready, input string tag,
                            input logic [3:0] eG, input logic [1:0] eM, input logic eV,
                            input logic [31:0] eD, input logic [3:0] eA, input logic eE);
        applyStimulus(req, ready);
        @(negedge clk);
        checkOutput(tag, eG, eM, eV, eD, eA, eE);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input string tag);
        rst = 1'b1;
        applyStimulus(4'b0000, 1'b0);
        #1;
        checkOutput(tag, 4'b0000, 2'd0, 1'b0, 32'd0, 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic modelReset();
        mOwner = -1;
        mPtr   = 0;
        mMux   = 0;
        mWait  = 0;
        mErr   = 1'b0;
    endtask

    // Owner is -1 when nobody holds the bus; the pointer names the next favoured requester.
    task automatic modelStep(input logic [3:0] req, input logic ready);
        int cand;
        if (mOwner < 0) begin
            for (int k = 0; k < 4; k++) begin
                cand = (mPtr + k) % 4;
                if (mOwner < 0 && req[cand]) begin
                    mOwner = cand;
                    mMux   = cand;
                end
            end
        end else if (ready) begin
            mPtr   = (mOwner + 1) % 4;
            mOwner = -1;
            mWait  = 0;
        end else begin
`ifdef ARB_TIMEOUT_EN
            mWait++;
            if (mWait == TO) begin
                mPtr   = (mOwner + 1) % 4;
                mOwner = -1;
                mWait  = 0;
                mErr   = 1'b1;
            end
`endif
        end
    endtask

    initial begin
        logic [3:0]  rReq;
        logic        rRdy;
        logic [3:0]  eG;
        logic [31:0] eD;

        rst = 1'b1;
        REQ = 4'b0000;
        RES_READY = 1'b0;
        DATA_A = DA;
        DATA_B = DB;
        DATA_C = DC;
        DATA_D = DD;

        tbl[0] = '{4'hF, 1'b1, 4'b0000, 2'd0, 1'b0, 32'd0, 4'b0000};
        tbl[1] = '{4'hF, 1'b1, 4'b0001, 2'd0, 1'b1, DA,    4'b0001};
        tbl[2] = '{4'hF, 1'b1, 4'b0000, 2'd0, 1'b0, 32'd0, 4'b0000};
        tbl[3] = '{4'hF, 1'b1, 4'b0010, 2'd1, 1'b1, DB,    4'b0010};
        tbl[4] = '{4'hF, 1'b1, 4'b0000, 2'd1, 1'b0, 32'd0, 4'b0000};
        tbl[5] = '{4'hF, 1'b1, 4'b0100, 2'd2, 1'b1, DC,    4'b0100};
        tbl[6] = '{4'hF, 1'b1, 4'b0000, 2'd2, 1'b0, 32'd0, 4'b0000};
        tbl[7] = '{4'hF, 1'b1, 4'b1000, 2'd3, 1'b1, DD,    4'b1000};
        tbl[8] = '{4'hF, 1'b1, 4'b0000, 2'd3, 1'b0, 32'd0, 4'b0000};
        tbl[9] = '{4'hF, 1'b1, 4'b0001, 2'd0, 1'b1, DA,    4'b0001};

        @(posedge clk);
        #1;
        doReset("reset");

        for (int i = 0; i < 10; i++)
            runCycle(tbl[i].req, tbl[i].ready, $sformatf("rr[%0d]", i), tbl[i].expGnt,
                     tbl[i].expMux, tbl[i].expValid, tbl[i].expData, tbl[i].expAck, 1'b0);

        // Requester 1 granted, resource ready on the third busy cycle.
        doReset("single.reset");
        DATA_B = 32'hDEAD_BEEF;
        runCycle(4'b0010, 1'b0, "single.idle", 4'b0000, 2'd0, 1'b0, 32'd0, 4'b0000, 1'b0);
        runCycle(4'b0010, 1'b0, "single.b1", 4'b0010, 2'd1, 1'b1, 32'hDEAD_BEEF, 4'b0000, 1'b0);
        runCycle(4'b0010, 1'b0, "single.b2", 4'b0010, 2'd1, 1'b1, 32'hDEAD_BEEF, 4'b0000, 1'b0);
        runCycle(4'b0010, 1'b1, "single.b3", 4'b0010, 2'd1, 1'b1, 32'hDEAD_BEEF, 4'b0010, 1'b0);
        runCycle(4'b0000, 1'b0, "single.done", 4'b0000, 2'd1, 1'b0, 32'd0, 4'b0000, 1'b0);
        DATA_B = DB;

        // Owner 3 completes, so the pointer wraps to requester 0.
        doReset("wrap.reset");
        runCycle(4'b1000, 1'b0, "wrap.idle", 4'b0000, 2'd0, 1'b0, 32'd0, 4'b0000, 1'b0);
        runCycle(4'b1001, 1'b1, "wrap.own3", 4'b1000, 2'd3, 1'b1, DD, 4'b1000, 1'b0);
        runCycle(4'b1001, 1'b0, "wrap.gap", 4'b0000, 2'd3, 1'b0, 32'd0, 4'b0000, 1'b0);
        runCycle(4'b1001, 1'b0, "wrap.next", 4'b0001, 2'd0, 1'b1, DA, 4'b0000, 1'b0);

        // Owner drops its request while the resource stalls; other requests are ignored.
        doReset("drop.reset");
        runCycle(4'b0010, 1'b0, "drop.idle", 4'b0000, 2'd0, 1'b0, 32'd0, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++)
            runCycle(4'b1100, 1'b0, $sformatf("drop.wait%0d", i), 4'b0010, 2'd1, 1'b1, DB, 4'b0000, 1'b0);
        runCycle(4'b0000, 1'b1, "drop.ack", 4'b0010, 2'd1, 1'b1, DB, 4'b0010, 1'b0);
        runCycle(4'b0000, 1'b0, "drop.done", 4'b0000, 2'd1, 1'b0, 32'd0, 4'b0000, 1'b0);

        // Reset asserted while requester 2 owns the bus, after the pointer has moved.
        doReset("rstBusy.reset");
        runCycle(4'b0010, 1'b0, "rstBusy.idle0", 4'b0000, 2'd0, 1'b0, 32'd0, 4'b0000, 1'b0);
        runCycle(4'b0100, 1'b1, "rstBusy.own1", 4'b0010, 2'd1, 1'b1, DB, 4'b0010, 1'b0);
        runCycle(4'b0100, 1'b0, "rstBusy.idle1", 4'b0000, 2'd1, 1'b0, 32'd0, 4'b0000, 1'b0);
        runCycle(4'b0100, 1'b0, "rstBusy.own2", 4'b0100, 2'd2, 1'b1, DC, 4'b0000, 1'b0);
        applyStimulus(4'b1111, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("rstBusy.now", 4'b0000, 2'd0, 1'b0, 32'd0, 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        runCycle(4'b1111, 1'b0, "rstBusy.rel", 4'b0000, 2'd0, 1'b0, 32'd0, 4'b0000, 1'b0);
        runCycle(4'b1111, 1'b0, "rstBusy.first", 4'b0001, 2'd0, 1'b1, DA, 4'b0000, 1'b0);

`ifdef ARB_TIMEOUT_EN
        doReset("to.reset");
        runCycle(4'b0001, 1'b0, "to.idle", 4'b0000, 2'd0, 1'b0, 32'd0, 4'b0000, 1'b0);
        for (int i = 0; i < TO; i++)
            runCycle(4'b0000, 1'b0, $sformatf("to.busy%0d", i), 4'b0001, 2'd0, 1'b1, DA, 4'b0000, 1'b0);
        runCycle(4'b0001, 1'b0, "to.aborted", 4'b0000, 2'd0, 1'b0, 32'd0, 4'b0000, 1'b1);
        runCycle(4'b0001, 1'b1, "to.sticky", 4'b0001, 2'd0, 1'b1, DA, 4'b0001, 1'b1);
        runCycle(4'b0000, 1'b0, "to.after", 4'b0000, 2'd0, 1'b0, 32'd0, 4'b0000, 1'b1);
        doReset("to.cleared");
        runCycle(4'b0001, 1'b0, "toLate.idle", 4'b0000, 2'd0, 1'b0, 32'd0, 4'b0000, 1'b0);
        for (int i = 0; i < TO - 1; i++)
            runCycle(4'b0000, 1'b0, $sformatf("toLate.busy%0d", i), 4'b0001, 2'd0, 1'b1, DA, 4'b0000, 1'b0);
        runCycle(4'b0000, 1'b1, "toLate.ack", 4'b0001, 2'd0, 1'b1, DA, 4'b0001, 1'b0);
        runCycle(4'b0000, 1'b0, "toLate.done", 4'b0000, 2'd0, 1'b0, 32'd0, 4'b0000, 1'b0);
`else
        doReset("noTo.reset");
        runCycle(4'b0001, 1'b0, "noTo.idle", 4'b0000, 2'd0, 1'b0, 32'd0, 4'b0000, 1'b0);
        for (int i = 0; i < 2 * TO + 8; i++)
            runCycle(4'b0000, 1'b0, $sformatf("noTo.wait%0d", i), 4'b0001, 2'd0, 1'b1, DA, 4'b0000, 1'b0);
        runCycle(4'b0000, 1'b1, "noTo.ack", 4'b0001, 2'd0, 1'b1, DA, 4'b0001, 1'b0);
`endif

        // Randomized traffic against the behavioural model.
        doReset("rand.reset");
        modelReset();
        for (int n = 0; n < 600; n++) begin
            rReq = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) rReq = 4'b0000;
            rRdy = ($urandom_range(0, 2) == 0);
            DATA_A = $urandom;
            DATA_B = $urandom;
            DATA_C = $urandom;
            DATA_D = $urandom;
            applyStimulus(rReq, rRdy);
            eG = (mOwner >= 0) ? 4'(1 << mOwner) : 4'b0000;
            case (mOwner)
                0:       eD = DATA_A;
                1:       eD = DATA_B;
                2:       eD = DATA_C;
                3:       eD = DATA_D;
                default: eD = 32'd0;
            endcase
            @(negedge clk);
            checkOutput($sformatf("rand[%0d]", n), eG, 2'(mMux), (mOwner >= 0), eD,
                        (mOwner >= 0 && rRdy) ? eG : 4'b0000, mErr);
            modelStep(rReq, rRdy);
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/bus_arbiter4.md
BUS_ARBITER4 -- requirements
Module: bus_arbiter4

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, cycles a grant may wait for RES_READY before abort (used only with ARB_TIMEOUT_EN).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port REQ  in  4  per-requester request; bit i = requester i.
REQ-005 SHALL have ports DATA_A, DATA_B, DATA_C, DATA_D  in  32 each  requester 0..3 payload, held stable while that requester is granted.
REQ-006 SHALL have port RES_READY  in  1  shared resource accepts BUS_DATA this cycle.
REQ-007 SHALL have port GNT  out  4  registered one-hot grant; all-zero when idle.
REQ-008 SHALL have port MUX_OP  out  2  registered binary index of current owner; drives the shared 4:1 select.
REQ-009 SHALL have port BUS_VALID  out  1  high exactly while in BUSY.
REQ-010 SHALL have port BUS_DATA  out  32  owner payload selected by MUX_OP; 0 when BUS_VALID low.
REQ-011 SHALL have port ACK  out  4  one-hot transfer-complete, combinational: GNT AND RES_READY while BUSY.
REQ-012 SHALL have port TIMEOUT_ERR  out  1  sticky timeout flag.

Function
REQ-013 SHALL implement two states: IDLE, BUSY.
REQ-014 IDLE, any REQ bit high: SHALL choose first requester at or after round-robin pointer PTR (wrapping 3->0), register GNT/MUX_OP, enter BUSY next cycle (REQ at edge N -> GNT high after edge N).
REQ-015 IDLE, REQ all zero: SHALL remain IDLE, GNT 0, MUX_OP unchanged.
REQ-016 BUSY with RES_READY high: SHALL assert ACK[owner] that cycle, then return to IDLE, clear GNT, set PTR = owner+1 mod 4.
REQ-017 BUSY with RES_READY low: SHALL hold GNT, MUX_OP, BUS_DATA unchanged.
REQ-018 Owner dropping REQ while BUSY SHALL NOT abort the transfer; changes on other REQ bits SHALL be ignored until IDLE.
REQ-019 Every transfer SHALL be followed by at least one IDLE cycle; no back-to-back grants.
REQ-020 All four REQ high continuously from PTR=0 SHALL yield grant order 0,1,2,3,0.

Reset
REQ-021 rst high SHALL immediately force: state IDLE, GNT 0, MUX_OP 0, PTR 0, BUS_VALID 0, BUS_DATA 0, ACK 0, TIMEOUT_ERR 0, wait counter 0.
REQ-022 rst asserted during BUSY SHALL drop the grant with no ACK; first grant after release SHALL start search from requester 0.

Configuration
REQ-023 Macro ARB_TIMEOUT_EN defined: SHALL count BUSY cycles with RES_READY low; on count reaching TIMEOUT_CYCLES SHALL return to IDLE without ACK, advance PTR past owner, set TIMEOUT_ERR (sticky until rst).
REQ-024 ARB_TIMEOUT_EN undefined: BUSY SHALL wait indefinitely, TIMEOUT_ERR tied 0, no counter logic.
REQ-025 RES_READY high on the timeout cycle SHALL take priority: normal ACK, no error.

Structure
REQ-026 Shared package arb_pkg SHALL hold NUM_REQ=4, DATA_W=32, SEL_W=2 and the IDLE/BUSY state type.
REQ-027 Round-robin selection SHALL be one combinational sub-module arb_rr_pick (inputs REQ, PTR; outputs one-hot pick, index, any).

Verification
REQ-028 Reset mid-BUSY, owner 2 -> GNT=0000, MUX_OP=0, ACK=0000, BUS_VALID=0 same cycle.
REQ-029 REQ=0010, DATA_B=0xDEADBEEF, RES_READY high 2 cycles after grant -> GNT=0010, MUX_OP=1, BUS_DATA=0xDEADBEEF, ACK=0010 on the third BUSY cycle, then IDLE.
REQ-030 REQ=1111 held, RES_READY=1 -> GNT sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
REQ-031 Owner 3, REQ=1001, completes -> next grant requester 0 (wrap).
REQ-032 Owner 1 drops REQ while RES_READY low 3 cycles -> grant held, ACK=0010 when RES_READY rises.
REQ-033 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, RES_READY stuck low -> after 16 BUSY cycles IDLE, ACK never set, TIMEOUT_ERR=1 until rst.
